// File: rtl/decode_cycle.sv
// RV32I decode stage: instruction decode, 32x32 register file with write-through,
// and the ID/EX pipeline register (cleared by reset or FlushE).
module decode_cycle #(
   parameter int unsigned NREG = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   input  logic        FlushE,
   output logic        RegWriteE,
   output logic [1:0]  ResultSrcE,
   output logic        MemWriteE,
   output logic        JumpE,
   output logic        BranchE,
   output logic [2:0]  ALUControlE,
   output logic        ALUSrcE,
   output logic [31:0] RD1E,
   output logic [31:0] RD2E,
   output logic [31:0] ImmExtE,
   output logic [4:0]  RdE,
   output logic [4:0]  Rs1E,
   output logic [4:0]  Rs2E,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E
);

   typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmJ} imm_src_e;

   typedef struct packed {
      logic        reg_write;
      logic [1:0]  result_src;
      logic        mem_write;
      logic        jump;
      logic        branch;
      logic [2:0]  alu_ctrl;
      logic        alu_src;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } idex_t;

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpRtype = 7'b0110011;
   localparam logic [6:0] OpItype = 7'b0010011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;

   logic [31:0] rf [NREG];
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2;
   imm_src_e    imm_src;
   idex_t       idex_d, idex_q;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign rs1    = InstrD[19:15];
   assign rs2    = InstrD[24:20];

   function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  alu_dec = sub ? 3'b001 : 3'b000;
         3'b111:  alu_dec = 3'b010;
         3'b110:  alu_dec = 3'b011;
         3'b010:  alu_dec = 3'b101;
         default: alu_dec = 3'b000;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (RegWriteW && (RdW != 5'd0)) begin
         rf[RdW] <= ResultW;
      end
   end

   always_comb begin
      idex_d          = '0;
      imm_src         = ImmNone;
      idex_d.rd       = InstrD[11:7];
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.pc       = PCD;
      idex_d.pc_plus4 = PCPlus4D;

      // Same-cycle writeback bypasses the array so decode sees the new value.
      if (rs1 != 5'd0) idex_d.rd1 = (RegWriteW && (RdW == rs1)) ? ResultW : rf[rs1];
      if (rs2 != 5'd0) idex_d.rd2 = (RegWriteW && (RdW == rs2)) ? ResultW : rf[rs2];

      case (opcode)
         OpLoad: begin
            idex_d.reg_write  = 1'b1;
            idex_d.alu_src    = 1'b1;
            idex_d.result_src = 2'b01;
            imm_src           = ImmI;
         end
         OpStore: begin
            idex_d.mem_write = 1'b1;
            idex_d.alu_src   = 1'b1;
            imm_src          = ImmS;
         end
         OpRtype: begin
            idex_d.reg_write = 1'b1;
            idex_d.alu_ctrl  = alu_dec(funct3, InstrD[30]);
         end
         OpItype: begin
            idex_d.reg_write = 1'b1;
            idex_d.alu_src   = 1'b1;
            idex_d.alu_ctrl  = alu_dec(funct3, 1'b0);
            imm_src          = ImmI;
         end
         OpBeq: begin
            idex_d.branch   = 1'b1;
            idex_d.alu_ctrl = 3'b001;
            imm_src         = ImmB;
         end
         OpJal: begin
            idex_d.reg_write  = 1'b1;
            idex_d.jump       = 1'b1;
            idex_d.result_src = 2'b10;
            imm_src           = ImmJ;
         end
         default: ;
      endcase

      case (imm_src)
         ImmI:    idex_d.imm = {{20{InstrD[31]}}, InstrD[31:20]};
         ImmS:    idex_d.imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         ImmB:    idex_d.imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                                InstrD[11:8], 1'b0};
         ImmJ:    idex_d.imm = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                                InstrD[30:21], 1'b0};
         default: idex_d.imm = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idex_q <= '0;
      end else if (FlushE) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign RegWriteE   = idex_q.reg_write;
   assign ResultSrcE  = idex_q.result_src;
   assign MemWriteE   = idex_q.mem_write;
   assign JumpE       = idex_q.jump;
   assign BranchE     = idex_q.branch;
   assign ALUControlE = idex_q.alu_ctrl;
   assign ALUSrcE     = idex_q.alu_src;
   assign RD1E        = idex_q.rd1;
   assign RD2E        = idex_q.rd2;
   assign ImmExtE     = idex_q.imm;
   assign RdE         = idex_q.rd;
   assign Rs1E        = idex_q.rs1;
   assign Rs2E        = idex_q.rs2;
   assign PCE         = idex_q.pc;
   assign PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed vector table, reset corner cases, then random
// instructions checked against a register-file/decoder reference model.
module tb_decode_cycle;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rsrc;
      logic        mw;
      logic        j;
      logic        b;
      logic [2:0]  alu;
      logic        asrc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] pc;
      logic [31:0] pc4;
   } out_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pcd;
      logic        rw;
      logic [4:0]  rdw;
      logic [31:0] resw;
      logic        flush;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RdW;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  RdE, Rs1E, Rs2E;

   out_t        act;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mrf [32];
   vec_t        tbl [14];

   always #5 clk = ~clk;

   decode_cycle #(.NREG(32)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   always_comb act = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                      ALUSrcE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E};

   function automatic out_t mk(input logic rw, input logic [1:0] rsrc, input logic mw,
                               input logic j, input logic b, input logic [2:0] alu,
                               input logic asrc, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] pc, input logic [31:0] pc4);
      mk = {rw, rsrc, mw, j, b, alu, asrc, rd1, rd2, imm, rd, rs1, rs2, pc, pc4};
   endfunction

   function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  alu_of = sub ? 3'b001 : 3'b000;
         3'b111:  alu_of = 3'b010;
         3'b110:  alu_of = 3'b011;
         3'b010:  alu_of = 3'b101;
         default: alu_of = 3'b000;
      endcase
   endfunction

   // Reference decode; immediates via arithmetic sign extension of the spliced fields.
   function automatic out_t model(input logic [31:0] ins, input logic [31:0] pcd,
                                  input logic [31:0] pc4, input logic [31:0] rd1v,
                                  input logic [31:0] rd2v);
      out_t        o;
      logic [31:0] i_imm;
      logic [12:0] b13;
      logic [20:0] j21;
      o      = '0;
      i_imm  = 32'($signed(ins) >>> 20);
      b13    = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      j21    = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      o.rd1  = rd1v;
      o.rd2  = rd2v;
      o.rd   = ins[11:7];
      o.rs1  = ins[19:15];
      o.rs2  = ins[24:20];
      o.pc   = pcd;
      o.pc4  = pc4;
      case (ins[6:0])
         7'h03: begin o.rw = 1'b1; o.rsrc = 2'b01; o.asrc = 1'b1; o.imm = i_imm; end
         7'h23: begin
            o.mw = 1'b1; o.asrc = 1'b1;
            o.imm = (i_imm & ~32'h1F) | {27'd0, ins[11:7]};
         end
         7'h33: begin o.rw = 1'b1; o.alu = alu_of(ins[14:12], ins[30]); end
         7'h13: begin
            o.rw = 1'b1; o.asrc = 1'b1; o.imm = i_imm; o.alu = alu_of(ins[14:12], 1'b0);
         end
         7'h63: begin o.b = 1'b1; o.alu = 3'b001; o.imm = 32'($signed(b13)); end
         7'h6F: begin o.rw = 1'b1; o.j = 1'b1; o.rsrc = 2'b10; o.imm = 32'($signed(j21)); end
         default: ;
      endcase
      model = o;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [2:0]  f3set [4];
      f3set = '{3'b000, 3'b111, 3'b110, 3'b010};
      ins = $urandom();
      case ($urandom_range(0, 7))
         0: ins[6:0] = 7'h03;
         1: ins[6:0] = 7'h23;
         2: begin ins[6:0] = 7'h33; ins[14:12] = f3set[$urandom_range(0, 3)]; end
         3: begin ins[6:0] = 7'h13; ins[14:12] = f3set[$urandom_range(0, 3)]; end
         4: ins[6:0] = 7'h63;
         5: ins[6:0] = 7'h6F;
         6: while (ins[6:0] inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F}) ins = $urandom();
         default: ins = '0;
      endcase
      rand_instr = ins;
   endfunction

   task automatic check(input string name, input out_t got, input out_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pcd, input logic rw,
                        input logic [4:0] rdw, input logic [31:0] resw, input logic fl);
      InstrD = ins; PCD = pcd; PCPlus4D = pcd + 32'd4;
      RegWriteW = rw; RdW = rdw; ResultW = resw; FlushE = fl;
   endtask

   initial begin
      out_t        exp;
      logic [31:0] ins, resw, rd1v, rd2v, pcd;
      logic [4:0]  rdw;
      logic        rw, fl;

      // Directed table, applied in order from an empty register file.
      tbl[0]  = '{32'h00700293, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 32'h7,
                     5'd5, 5'd0, 5'd7, 32'h10, 32'h14)};
      tbl[1]  = '{32'h00000000, 32'h14, 1'b1, 5'd2, 32'h100, 1'b0,
                  mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0,
                     5'd0, 5'd0, 5'd0, 32'h14, 32'h18)};
      tbl[2]  = '{32'h00612423, 32'h18, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 32'h100, 32'h0, 32'h8,
                     5'd8, 5'd2, 5'd6, 32'h18, 32'h1C)};
      tbl[3]  = '{32'h402081B3, 32'h1C, 1'b1, 5'd1, 32'h1234, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'h1234, 32'h100, 32'h0,
                     5'd3, 5'd1, 5'd2, 32'h1C, 32'h20)};
      tbl[4]  = '{32'h00700293, 32'h20, 1'b1, 5'd0, 32'hDEAD, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 32'h7,
                     5'd5, 5'd0, 5'd7, 32'h20, 32'h24)};
      tbl[5]  = '{32'h00700293, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 32'h7,
                     5'd5, 5'd0, 5'd7, 32'h24, 32'h28)};
      tbl[6]  = '{32'hFE208CE3, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'h1234, 32'h100, 32'hFFFFFFF8,
                     5'd25, 5'd1, 5'd2, 32'h40, 32'h44)};
      tbl[7]  = '{32'h00700293, 32'h48, 1'b0, 5'd0, 32'h0, 1'b1, out_t'(0)};
      tbl[8]  = '{32'h00700293, 32'h4C, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 32'h7,
                     5'd5, 5'd0, 5'd7, 32'h4C, 32'h50)};
      tbl[9]  = '{32'h010000EF, 32'h50, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h10,
                     5'd1, 5'd0, 5'd16, 32'h50, 32'h54)};
      tbl[10] = '{32'hFFC12383, 32'h54, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h100, 32'h0, 32'hFFFFFFFC,
                     5'd7, 5'd2, 5'd28, 32'h54, 32'h58)};
      tbl[11] = '{32'h0020F233, 32'h58, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 32'h1234, 32'h100, 32'h0,
                     5'd4, 5'd1, 5'd2, 32'h58, 32'h5C)};
      tbl[12] = '{32'hFFF0A313, 32'h5C, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 32'h1234, 32'h0, 32'hFFFFFFFF,
                     5'd6, 5'd1, 5'd31, 32'h5C, 32'h60)};
      tbl[13] = '{32'h40010493, 32'h60, 1'b0, 5'd0, 32'h0, 1'b0,
                  mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h100, 32'h0, 32'h400,
                     5'd9, 5'd2, 5'd0, 32'h60, 32'h64)};

      drive(32'h00700293, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0);
      #2 rst = 1'b0;
      #1 check("reset_async", act, '0);
      repeat (2) @(posedge clk);
      #1 check("reset_hold", act, '0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].instr, tbl[i].pcd, tbl[i].rw, tbl[i].rdw, tbl[i].resw, tbl[i].flush);
         @(posedge clk);
         #1 check($sformatf("vec%0d", i), act, tbl[i].exp);
      end

      // Reset between edges must clear outputs and register file immediately.
      @(negedge clk);
      drive(32'h00700293, 32'h70, 1'b0, 5'd0, 32'h0, 1'b0);
      #2 rst = 1'b0;
      #1 check("midop_reset", act, '0);
      @(posedge clk);
      #1 check("midop_reset_hold", act, '0);
      @(negedge clk);
      drive(32'hFFC12383, 32'h80, 1'b0, 5'd0, 32'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 check("first_edge_after_reset", act,
               mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFC,
                  5'd7, 5'd2, 5'd28, 32'h80, 32'h84));

      foreach (mrf[i]) mrf[i] = '0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         ins  = rand_instr();
         pcd  = $urandom() & ~32'h3;
         rw   = $urandom_range(0, 1) == 1;
         rdw  = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 31));
         resw = $urandom();
         fl   = $urandom_range(0, 7) == 0;
         drive(ins, pcd, rw, rdw, resw, fl);
         // Writing the model first gives the write-through read for free.
         if (rw && rdw != 5'd0) mrf[rdw] = resw;
         rd1v = mrf[ins[19:15]];
         rd2v = mrf[ins[24:20]];
         exp  = fl ? out_t'(0) : model(ins, pcd, pcd + 32'd4, rd1v, rd2v);
         @(posedge clk);
         #1 check($sformatf("rand%0d", n), act, exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Decode stage of the 5-stage RV32I pipeline. It consumes the IF/ID register outputs (InstrD, PCD, PCPlus4D) from the fetch stage and decodes the instruction into control signals and a sign-extended immediate. It reads the 32x32 register file, which is written from writeback, and registers everything into the ID/EX pipeline register for the execute stage. FlushE squashes the ID/EX contents on a taken branch or jump.

Parameters:
NREG, 32, number of architectural registers (x0 hardwired to zero)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
InstrD  input  32  instruction from IF/ID
PCD  input  32  PC of InstrD
PCPlus4D  input  32  PCD+4
RegWriteW  input  1  writeback enable
RdW  input  5  writeback destination
ResultW  input  32  writeback data
FlushE  input  1  clear ID/EX on next edge
RegWriteE  output  1  register write enable
ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
MemWriteE  output  1  store
JumpE  output  1  jal
BranchE  output  1  beq
ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcE  output  1  0 = RD2, 1 = immediate
RD1E, RD2E  output  32  register operands
ImmExtE  output  32  sign-extended immediate
RdE, Rs1E, Rs2E  output  5  register indices
PCE, PCPlus4E  output  32  PC values passed through

Behaviour:
- Reset: rst=0 asynchronously clears all ID/EX outputs and all register-file entries to 0, and holds them at 0 while rst is low.
- Latency: 1 cycle. Fields of InstrD are decoded combinationally, and all E outputs update on the next rising edge.
- Register file:
  - Write on rising edge when RegWriteW=1 and RdW!=0.
  - Writes to x0 are ignored; reads of x0 always return 0.
  - Write-through: if RegWriteW=1, RdW!=0 and RdW equals rs1 (or rs2), the read returns ResultW in the same cycle.
- Decoded opcodes (all other opcodes decode to all-zero control, i.e. a bubble):
  - 0000011 lw: RegWrite=1, ImmSrc=I, ALUSrc=1, ResultSrc=01, ALU add.
  - 0100011 sw: MemWrite=1, ImmSrc=S, ALUSrc=1, ALU add.
  - 0110011 R-type: RegWrite=1, ALUSrc=0. ALU op from funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ImmSrc=I. Same funct3 mapping; addi always add, funct7 ignored.
  - 1100011 beq: Branch=1, ImmSrc=B, ALU sub.
  - 1101111 jal: RegWrite=1, Jump=1, ImmSrc=J, ResultSrc=10.
- Immediates (sign bit is Instr[31]):
  - I = {Instr[31:20]}
  - S = {Instr[31:25], Instr[11:7]}
  - B = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}
  - J = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}
  - R-type: ImmExtE = 0.
- Index fields: Rs1E=Instr[19:15], Rs2E=Instr[24:20], RdE=Instr[11:7], captured for every opcode.
- FlushE=1 at an edge: all ID/EX outputs load 0, overriding decode. The register-file write in that cycle still occurs.
- Reset mid-operation: outputs clear immediately, with no wait for a clock edge. The first edge after rst rises captures the current InstrD.
- InstrD=0 (the fetch reset value) decodes as a bubble: all control 0.

Test Plan:
- Reset: hold rst=0, apply InstrD=0x00700293 -> all outputs 0; release -> after 1 edge RegWriteE=1, ALUSrcE=1, ImmExtE=0x00000007, RdE=5, ALUControlE=000.
- Write then read: RegWriteW=1, RdW=2, ResultW=0x100, then InstrD=0x00612423 (sw x6,8(x2)) -> MemWriteE=1, RD1E=0x100, ImmExtE=0x00000008, RegWriteE=0.
- Write-through: same cycle RegWriteW=1, RdW=1, ResultW=0x1234 and InstrD=0x402081B3 (sub x3,x1,x2) -> RD1E=0x1234, ALUControlE=001, RdE=3.
- x0 protection: RegWriteW=1, RdW=0, ResultW=0xDEAD, then read x0 via 0x00700293 -> RD1E=0.
- Branch immediate: InstrD=0xFE208CE3 (beq x1,x2,-8), PCD=0x40 -> BranchE=1, ImmExtE=0xFFFFFFF8, PCE=0x40, ALUControlE=001.
- Flush: InstrD=0x00700293 with FlushE=1 -> after edge all outputs 0; FlushE=0 next cycle -> decoded values appear.
